rx_drain_ctrl: RTL

Receive-side controller that sequences the UART receive engine.
- Watches the engine's RxRdy.
- Captures the received byte together with its PERR/FERR/OVF status into a small FIFO.
- Issues the single-cycle read_0 acknowledge that clears the engine's ready and error flops.
- The host side pops entries from the FIFO at its own pace and gets a level/error interrupt. The block sits between receiveEngine and the CPU register interface.

---
 rtl/rx_drain_ctrl.sv | 88 ++++++++
 1 files changed

// File: rtl/rx_drain_ctrl.sv
// Receive drain controller: captures engine bytes with their error status into a FIFO and acks the engine.
// Latency: 1 clk from RxRdy to entry visible and to read_0. The engine is held off (no ack) while the FIFO is full.
module rx_drain_ctrl #(
   parameter int DEPTH     = 8,
   parameter int AW        = 3,
   parameter int IRQ_LEVEL = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          RxRdy,
   input  logic [7:0]    rx_data,
   input  logic          PERR,
   input  logic          FERR,
   input  logic          OVF,
   output logic          read_0,
   input  logic          pop,
   output logic [10:0]   rd_data,
   output logic          rd_valid,
   output logic [AW:0]   count,
   output logic          full,
   output logic          irq,
   output logic          underflow
);

   typedef enum logic [1:0] {IDLE, ACK, SETTLE} state_t;

   localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW:0]   IRQ_C   = (AW+1)'(IRQ_LEVEL);
   localparam logic [AW:0]   CNT_ONE = 1;
   localparam logic [AW-1:0] PTR_ONE = 1;

   state_t        state;
   logic [10:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push;
   logic          pop_ok;

   assign full     = (count == DEPTH_C);
   assign rd_valid = (count != '0);
   assign rd_data  = rd_valid ? mem[rd_ptr] : 11'h000;
   assign read_0   = (state == ACK);

   // A pop while empty is never honoured, even if a push lands on the same edge.
   assign push   = (state == IDLE) && RxRdy && !full;
   assign pop_ok = pop && rd_valid;

   // Status travels with the byte, sampled before read_0 clears the engine flags.
   always_ff @(posedge clk) begin
      if (!reset && push)
         mem[wr_ptr] <= {PERR, FERR, OVF, rx_data};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         irq       <= 1'b0;
         underflow <= 1'b0;
      end else begin
         case (state)
            IDLE:    if (push) state <= ACK;
            ACK:     state <= SETTLE;
            SETTLE:  state <= IDLE;
            default: state <= IDLE;
         endcase

         if (push)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (pop_ok)
            rd_ptr <= rd_ptr + PTR_ONE;

         case ({push, pop_ok})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase

         if (pop && !rd_valid)
            underflow <= 1'b1;

         irq <= (count >= IRQ_C) | (rd_valid & (rd_data[10] | rd_data[9] | rd_data[8]));
      end
   end

endmodule
